// File: rtl/exhaustive_vector_tester_pkg.sv
// Shared types for the exhaustive vector tester.
// Holds the FSM state encoding and the settle-counter width helper.
package exhaustive_vector_tester_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_APPLY = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // A counter that only ever holds SETTLE-1 still needs one bit.
    function automatic int settle_cnt_w(input int settle);
        return (settle > 1) ? $clog2(settle) : 1;
    endfunction

endpackage

// File: rtl/exhaustive_vector_tester_if.sv
// Board-side bundle of the vector tester: start control, stimulus,
// the two compared outputs and the status/result signals.
interface exhaustive_vector_tester_if #(
    parameter int IN_W  = 2,
    parameter int OUT_W = 1,
    parameter int ERR_W = 16
);
    logic             start;
    logic [IN_W-1:0]  vec_out;
    logic [OUT_W-1:0] dut_y;
    logic [OUT_W-1:0] exp_y;
    logic             busy;
    logic             done;
    logic             pass;
    logic [ERR_W-1:0] err_count;
    logic             first_err_valid;
    logic [IN_W-1:0]  first_err_vec;

    modport master (
        input  start, dut_y, exp_y,
        output vec_out, busy, done, pass,
        output err_count, first_err_valid, first_err_vec
    );

    modport slave (
        output start, dut_y, exp_y,
        input  vec_out, busy, done, pass,
        input  err_count, first_err_valid, first_err_vec
    );

endinterface

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
// Synchronous clear; reset and clear both return it to zero.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (inc && (q != {W{1'b1}})) begin
            q <= q + W'(1);
        end
    end

endmodule

// File: rtl/exhaustive_vector_tester.sv
// Sweeps every IN_W-bit vector, holds each SETTLE cycles, then
// compares the unit output against the golden output and logs errors.
module exhaustive_vector_tester
    import exhaustive_vector_tester_pkg::*;
#(
    parameter int IN_W   = 2,
    parameter int OUT_W  = 1,
    parameter int SETTLE = 2,
    parameter int ERR_W  = 16
) (
    input logic                     clk,
    input logic                     rst_n,
    exhaustive_vector_tester_if.master bus
);

    localparam int CW = settle_cnt_w(SETTLE);
    localparam logic [CW-1:0] CNT_LOAD = CW'(SETTLE - 1);
    localparam logic [IN_W-1:0] VEC_LAST = {IN_W{1'b1}};

    state_t            state;
    logic [CW-1:0]     cnt;
    logic [IN_W-1:0]   vec;
    logic              busy_r;
    logic              done_r;
    logic              fev_r;
    logic [IN_W-1:0]   fevec_r;
    logic [ERR_W-1:0]  err_q;
    logic [OUT_W-1:0]  dy;
    logic [OUT_W-1:0]  ey;
    logic              mismatch;
    logic              launch;
    logic              in_check;

    assign dy       = bus.dut_y;
    assign ey       = bus.exp_y;
    assign in_check = (state == ST_CHECK);
    assign mismatch = in_check && (dy != ey);

    // start only matters while parked; a running sweep cannot be aborted.
    assign launch = bus.start &&
                    ((state == ST_IDLE) || (state == ST_DONE));

    sat_counter #(
        .W (ERR_W)
    ) u_err_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (launch),
        .inc   (mismatch),
        .q     (err_q)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            vec     <= '0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            fev_r   <= 1'b0;
            fevec_r <= '0;
        end else begin
            unique case (state)
                ST_IDLE, ST_DONE: begin
                    if (bus.start) begin
                        state   <= ST_APPLY;
                        cnt     <= CNT_LOAD;
                        vec     <= '0;
                        busy_r  <= 1'b1;
                        done_r  <= 1'b0;
                        fev_r   <= 1'b0;
                        fevec_r <= '0;
                    end
                end
                ST_APPLY: begin
                    if (cnt == '0) begin
                        state <= ST_CHECK;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                ST_CHECK: begin
                    if (mismatch && !fev_r) begin
                        fev_r   <= 1'b1;
                        fevec_r <= vec;
                    end
                    // Terminate on the last vector, never on wrap.
                    if (vec == VEC_LAST) begin
                        state  <= ST_DONE;
                        busy_r <= 1'b0;
                        done_r <= 1'b1;
                    end else begin
                        state <= ST_APPLY;
                        vec   <= vec + IN_W'(1);
                        cnt   <= CNT_LOAD;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.vec_out         = vec;
    assign bus.busy            = busy_r;
    assign bus.done            = done_r;
    assign bus.err_count       = err_q;
    assign bus.pass            = done_r && (err_q == '0);
    assign bus.first_err_valid = fev_r;
    assign bus.first_err_vec   = fevec_r;

endmodule

// File: tb/tb_exhaustive_vector_tester.sv
// Directed bench: three tester instances with different parameters,
// a table of fault modes for the default one, plus corner sequences.
module tb_exhaustive_vector_tester;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail = 0;
    int   mode = 0;

    always #5 clk = ~clk;

    exhaustive_vector_tester_if #(.IN_W(2), .OUT_W(1), .ERR_W(16)) b0();
    exhaustive_vector_tester_if #(.IN_W(3), .OUT_W(1), .ERR_W(2))  b1();
    exhaustive_vector_tester_if #(.IN_W(1), .OUT_W(1), .ERR_W(16)) b2();

    // Unit 0: AND golden; unit faulted on selected vectors by mode.
    function automatic bit fault0(input int m, input logic [1:0] v);
        case (m)
            1:       return (v == 2'd2);
            2:       return 1'b1;
            3:       return (v == 2'd1) || (v == 2'd3);
            default: return 1'b0;
        endcase
    endfunction

    logic g0;
    assign g0 = b0.vec_out[0] & b0.vec_out[1];
    assign b0.exp_y = g0;
    assign b0.dut_y = fault0(mode, b0.vec_out) ? ~g0 : g0;

    assign b1.exp_y = &b1.vec_out;
    assign b1.dut_y = ~(&b1.vec_out);

    assign b2.exp_y = b2.vec_out;
    assign b2.dut_y = b2.vec_out;

    exhaustive_vector_tester #(
        .IN_W(2), .OUT_W(1), .SETTLE(2), .ERR_W(16)
    ) u0 (.clk(clk), .rst_n(rst_n), .bus(b0));

    exhaustive_vector_tester #(
        .IN_W(3), .OUT_W(1), .SETTLE(2), .ERR_W(2)
    ) u1 (.clk(clk), .rst_n(rst_n), .bus(b1));

    exhaustive_vector_tester #(
        .IN_W(1), .OUT_W(1), .SETTLE(1), .ERR_W(16)
    ) u2 (.clk(clk), .rst_n(rst_n), .bus(b2));

    typedef struct {
        int mode;
        int err;
        bit fev;
        int fevec;
        bit pass;
    } vec_t;

    vec_t tbl [4];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_start(input int s, input logic v);
        case (s)
            0:       b0.start = v;
            1:       b1.start = v;
            default: b2.start = v;
        endcase
    endtask

    function automatic logic get_done(input int s);
        case (s)
            0:       return b0.done;
            1:       return b1.done;
            default: return b2.done;
        endcase
    endfunction

    // Returns just after the edge that samples start high.
    task automatic pulse_start(input int s);
        set_start(s, 1'b1);
        tick();
        set_start(s, 1'b0);
    endtask

    task automatic wait_done(input int s, input int lim, output int n);
        n = 0;
        while (!get_done(s) && (n < lim)) begin
            tick();
            n++;
        end
        chk("done_reached", 32'(get_done(s)), 32'd1);
    endtask

    task automatic chk_reset0(input string tag);
        chk({tag, "_vec"},   32'(b0.vec_out), 32'd0);
        chk({tag, "_busy"},  32'(b0.busy), 32'd0);
        chk({tag, "_done"},  32'(b0.done), 32'd0);
        chk({tag, "_err"},   32'(b0.err_count), 32'd0);
        chk({tag, "_fev"},   32'(b0.first_err_valid), 32'd0);
        chk({tag, "_fevec"}, 32'(b0.first_err_vec), 32'd0);
        chk({tag, "_pass"},  32'(b0.pass), 32'd0);
    endtask

    initial begin
        int n;
        tbl[0] = '{mode: 0, err: 0, fev: 1'b0, fevec: 0, pass: 1'b1};
        tbl[1] = '{mode: 1, err: 1, fev: 1'b1, fevec: 2, pass: 1'b0};
        tbl[2] = '{mode: 2, err: 4, fev: 1'b1, fevec: 0, pass: 1'b0};
        tbl[3] = '{mode: 3, err: 2, fev: 1'b1, fevec: 1, pass: 1'b0};

        b0.start = 1'b0;
        b1.start = 1'b0;
        b2.start = 1'b0;
        rst_n = 1'b0;
        tick();
        tick();
        chk_reset0("rst");
        chk("rst_err1", 32'(b1.err_count), 32'd0);
        chk("rst_done2", 32'(b2.done), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("idle_hold", 32'(b0.busy), 32'd0);

        // Back-to-back sweeps restart from DONE without a reset.
        for (int i = 0; i < 4; i++) begin
            mode = tbl[i].mode;
            pulse_start(0);
            chk("tbl_busy", 32'(b0.busy), 32'd1);
            wait_done(0, 40, n);
            chk("tbl_edges", 32'(n), 32'd12);
            chk("tbl_err", 32'(b0.err_count), 32'(tbl[i].err));
            chk("tbl_fev", 32'(b0.first_err_valid), 32'(tbl[i].fev));
            chk("tbl_fevec", 32'(b0.first_err_vec), 32'(tbl[i].fevec));
            chk("tbl_pass", 32'(b0.pass), 32'(tbl[i].pass));
            chk("tbl_idle", 32'(b0.busy), 32'd0);
            chk("tbl_vec", 32'(b0.vec_out), 32'd3);
        end

        // NAND vs AND over 3 bits, 2-bit saturating error count.
        pulse_start(1);
        wait_done(1, 60, n);
        chk("sat_edges", 32'(n), 32'd24);
        chk("sat_err", 32'(b1.err_count), 32'd3);
        chk("sat_fev", 32'(b1.first_err_valid), 32'd1);
        chk("sat_fevec", 32'(b1.first_err_vec), 32'd0);
        chk("sat_pass", 32'(b1.pass), 32'd0);

        // SETTLE=1, IN_W=1: two cycles per vector.
        pulse_start(2);
        chk("s1_vec_a", 32'(b2.vec_out), 32'd0);
        tick();
        chk("s1_vec_b", 32'(b2.vec_out), 32'd0);
        tick();
        chk("s1_vec_c", 32'(b2.vec_out), 32'd1);
        tick();
        chk("s1_vec_d", 32'(b2.vec_out), 32'd1);
        chk("s1_notdone", 32'(b2.done), 32'd0);
        tick();
        chk("s1_done", 32'(b2.done), 32'd1);
        chk("s1_pass", 32'(b2.pass), 32'd1);
        chk("s1_vec_e", 32'(b2.vec_out), 32'd1);

        // Reset in the middle of a sweep, after one error is logged.
        mode = 2;
        pulse_start(0);
        tick();
        tick();
        tick();
        chk("mid_vec", 32'(b0.vec_out), 32'd1);
        chk("mid_busy", 32'(b0.busy), 32'd1);
        chk("mid_err", 32'(b0.err_count), 32'd1);
        chk("mid_fev", 32'(b0.first_err_valid), 32'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk_reset0("mid_rst");
        tick();
        chk("mid_stay_idle", 32'(b0.busy), 32'd0);
        mode = 0;
        pulse_start(0);
        wait_done(0, 40, n);
        chk("mid_re_edges", 32'(n), 32'd12);
        chk("mid_re_pass", 32'(b0.pass), 32'd1);

        // start held high: no mid-sweep restart, restart right after DONE.
        mode = 1;
        b0.start = 1'b1;
        tick();
        for (int j = 0; j < 12; j++) begin
            chk("hold_vec", 32'(b0.vec_out), 32'(j / 3));
            chk("hold_busy", 32'(b0.busy), 32'd1);
            tick();
        end
        chk("hold_done", 32'(b0.done), 32'd1);
        chk("hold_err", 32'(b0.err_count), 32'd1);
        chk("hold_fevec", 32'(b0.first_err_vec), 32'd2);
        tick();
        b0.start = 1'b0;
        chk("rs_done", 32'(b0.done), 32'd0);
        chk("rs_err", 32'(b0.err_count), 32'd0);
        chk("rs_vec", 32'(b0.vec_out), 32'd0);
        chk("rs_busy", 32'(b0.busy), 32'd1);
        chk("rs_fev", 32'(b0.first_err_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/exhaustive_vector_tester.md
Name: exhaustive_vector_tester

Overview:
Synthesizable, parametrised self-checking stimulus engine. It is the hardware successor to the team's fixed two-input simulation bench. It sweeps every input combination of an IN_W-bit combinational unit under test, and compares the unit's output against a golden-model output on each vector. It also counts mismatches, records the first failing vector, and reports pass/fail. It sits between a board-level start control (switch/button) and status LEDs, wrapping any small combinational lab module.

Parameters:
IN_W, 2, width of stimulus vector; 1..16.
OUT_W, 1, width of compared output; 1..32.
SETTLE, 2, cycles each vector is held before comparison; >=1.
ERR_W, 16, width of error counter; saturating.

Ports:
clk  in  1  single system clock; all logic on rising edge.
rst_n  in  1  synchronous, active-low reset, sampled on rising clk edge.
start  in  1  level; sampled each clk; begins a sweep from IDLE or DONE.
vec_out  out  IN_W  stimulus driven to the unit under test and to the golden model.
dut_y  in  OUT_W  output of unit under test (combinational from vec_out).
exp_y  in  OUT_W  golden-model output (combinational from vec_out).
busy  out  1  high while sweep in progress (APPLY/CHECK).
done  out  1  high from sweep completion until next start or reset.
pass  out  1  done && (err_count == 0).
err_count  out  ERR_W  mismatching vectors this sweep; saturates at all-ones.
first_err_valid  out  1  a mismatch has been recorded this sweep.
first_err_vec  out  IN_W  vec_out of first mismatch; 0 when !first_err_valid.

Behaviour:
- Reset (rst_n=0 at edge) has priority over everything, including mid-sweep:
  - state=IDLE; vec_out=0; busy=0; done=0; err_count=0; first_err_valid=0; first_err_vec=0; settle counter=0.
  - pass is derived, so it is 0.
- State machine:
  - IDLE: start=1 -> clear err_count, first_err_*, done; vec_out=0; settle cnt=SETTLE-1; go to APPLY. Otherwise stay.
  - APPLY: busy=1. If cnt==0, go to CHECK; else decrement cnt. vec_out stays stable.
  - CHECK: busy=1. Compare dut_y vs exp_y in this cycle, using all OUT_W bits with exact inequality.
    - On mismatch: err_count += 1 unless all-ones (saturate, no wrap). If !first_err_valid, set first_err_valid=1 and first_err_vec=vec_out.
    - If vec_out == all-ones (2^IN_W-1), go to DONE. vec_out stays at final value.
    - Otherwise vec_out += 1, cnt=SETTLE-1, go to APPLY.
  - DONE: busy=0, done=1; results held. start=1 -> same action as from IDLE (restart).
- start is ignored in APPLY/CHECK; no abort except reset.
- Timing: with start sampled high at edge k, vector v's CHECK cycle is the cycle after edge k+(v+1)*SETTLE+v.
  - Each vector occupies SETTLE+1 cycles.
  - done first high after edge k + 2^IN_W*(SETTLE+1).
  - For defaults this is 12 edges after the start edge.
- Vector counter reaches all-ones without wrap; termination is by comparison, not overflow.
- Error insertion occurs only in CHECK; dut_y/exp_y are don't-care elsewhere.

Decomposition:
- Shared include file: state encoding localparams (ST_IDLE, ST_APPLY, ST_CHECK, ST_DONE; 2-bit) and the $clog2-based settle-counter width helper.
- One sub-module is natural: sat_counter (parameter W; inputs clk, rst_n, clr, inc; output q; saturates at all-ones), used for err_count.
- The golden model and the unit under test are external; the bench instantiates both.

Test Plan:
1. Defaults, unit = 2-input AND, golden = AND; pulse start -> done rises 12 edges after start edge; pass=1; err_count=0; first_err_valid=0.
2. Unit output forced inverted only when vec_out=2 -> err_count=1; first_err_valid=1; first_err_vec=2; pass=0.
3. Unit = NAND vs golden AND (all wrong); IN_W=3, ERR_W=2 -> err_count saturates at 3, not 0; first_err_vec=0; done after 8*3 edges.
4. Assert rst_n=0 for one edge while vec_out=1 in APPLY -> next cycle all outputs at reset values, state IDLE; a new start completes a clean sweep with pass=1.
5. Hold start high throughout a sweep -> no restart mid-sweep; vec_out increments 0,1,2,3. In the cycle after DONE is entered, start restarts: done drops, err_count clears, vec_out=0.
6. SETTLE=1, IN_W=1 -> vec_out holds 0 for 2 cycles, then 1 for 2 cycles; done after 4 edges.
